ulpi_reg_engine: RTL and testbench

Parametrised ULPI PHY register-access engine and the successor to the fixed 6-bit CSR bridge in the ULPI controller. It bridges an AXI-Lite slave port to the ULPI byte-stream layer (TX command stream out, RX byte stream in). Over the old bridge it adds extended-register access (0x2F escape), a bounded retry on PHY bus takeover, a read-data timeout, and error responses. It sits between the CSR interconnect and ulpi_axis, beside the USB state and RX-packet logic.

---
 rtl/ulpi_pkg.sv | 22 ++
 rtl/ulpi_reg_engine.sv | 156 +++++++++++++++
 tb/tb_ulpi_reg_engine.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared constants, state encoding and helpers for the ULPI register-access engine.
package ulpi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;
  localparam logic [5:0] EXT_REG_ADDR = 6'h2F;
  localparam logic [1:0] RXU_REGDATA = 2'b01;
  localparam logic [1:0] RXU_ACTIVE  = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_CMD, S_EXT, S_WDATA, S_RD_WAIT, S_ABORT, S_RESP
  } state_t;
  // 0x2F is the escape code itself, so it is never a real register.
  function automatic logic [1:0] decode(input logic [8:0] a, input logic ext_en);
    return a[8] ? RESP_DECERR :
           (a == 9'h02F || (|a[7:6] && !ext_en)) ? RESP_SLVERR : RESP_OKAY;
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic [1:0] r);
    return c + 8'((r != RESP_OKAY) && (c != 8'hFF));
  endfunction
endpackage

// File: rtl/ulpi_reg_engine.sv
// ulpi_reg_engine: AXI-Lite to ULPI register access bridge with extended access, retry and timeout.
module ulpi_reg_engine
  import ulpi_pkg::*;
#(
  parameter int CSR_ADDR_W = 12,
  parameter int CSR_DATA_W = 32,
  parameter int EXT_EN     = 1,
  parameter int MAX_RETRY  = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CSR_ADDR_W-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [CSR_DATA_W-1:0]   s_wdata,
  input  logic [CSR_DATA_W/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [CSR_ADDR_W-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [CSR_DATA_W-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [7:0]              tx_tdata,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic                    tx_tlast,
  input  logic [7:0]              rx_tdata,
  input  logic                    rx_tvalid,
  input  logic [1:0]              rx_tuser,
  output logic                    busy,
  output logic [7:0]              err_count
);
  state_t      r_state;
  logic [8:0]  r_addr;
  logic        r_is_wr;
  logic [7:0]  r_wdata;
  logic        r_wstrb;
  logic [7:0]  r_rdata;
  logic [1:0]  r_resp;
  logic [3:0]  r_retry;
  logic [15:0] r_timer;
  logic [7:0]  r_err_count;
  logic        w_ext;
  logic [1:0]  w_pre;
  logic [1:0]  w_ar_dec;
  logic [1:0]  w_w_dec;
  logic        w_unused;
  assign w_ext    = |r_addr[7:6];
  assign w_pre    = r_is_wr ? CMD_REGW : CMD_REGR;
  assign w_ar_dec = decode(s_araddr[8:0], EXT_EN != 0);
  assign w_w_dec  = decode(r_addr, EXT_EN != 0);
  assign w_unused = &{1'b0, s_awaddr[CSR_ADDR_W-1:9], s_araddr[CSR_ADDR_W-1:9],
                      s_wdata[CSR_DATA_W-1:8], s_wstrb[CSR_DATA_W/8-1:1]};
  assign s_awready = r_state == S_IDLE;
  assign s_arready = r_state == S_IDLE && !s_awvalid;
  assign s_wready  = r_state == S_WAIT_W;
  assign s_bvalid  = r_state == S_RESP && r_is_wr;
  assign s_rvalid  = r_state == S_RESP && !r_is_wr;
  assign s_bresp   = r_resp;
  assign s_rresp   = r_resp;
  assign s_rdata   = {{(CSR_DATA_W-8){1'b0}}, r_rdata};
  assign busy      = r_state != S_IDLE;
  assign err_count = r_err_count;
  assign tx_tvalid = r_state == S_CMD || r_state == S_EXT || r_state == S_WDATA;
  assign tx_tdata  = r_state == S_CMD ? {w_pre, w_ext ? EXT_REG_ADDR : r_addr[5:0]} :
                     r_state == S_EXT ? r_addr[7:0] : r_wdata;
  assign tx_tlast  = r_state == S_WDATA || (r_state == S_EXT && !r_is_wr) ||
                     (r_state == S_CMD && !r_is_wr && !w_ext);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_is_wr     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= RESP_OKAY;
      r_retry     <= '0;
      r_timer     <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_retry <= '0;
          if (s_awvalid) begin
            r_addr  <= s_awaddr[8:0];
            r_is_wr <= 1'b1;
            r_rdata <= '0;
            r_state <= S_WAIT_W;
          end else if (s_arvalid) begin
            r_addr      <= s_araddr[8:0];
            r_is_wr     <= 1'b0;
            r_rdata     <= '0;
            r_resp      <= w_ar_dec;
            r_err_count <= sat_inc(r_err_count, w_ar_dec);
            r_state     <= w_ar_dec == RESP_OKAY ? S_CMD : S_RESP;
          end
        end
        S_WAIT_W: if (s_wvalid) begin
          r_wdata     <= s_wdata[7:0];
          r_wstrb     <= s_wstrb[0];
          r_resp      <= w_w_dec;
          r_err_count <= sat_inc(r_err_count, w_w_dec);
          r_state     <= (w_w_dec != RESP_OKAY || !s_wstrb[0]) ? S_RESP : S_CMD;
        end
        S_CMD: if (rx_tvalid) r_state <= S_ABORT;
          else if (tx_tready) begin
            r_timer <= '0;
            r_state <= w_ext ? S_EXT : r_is_wr ? S_WDATA : S_RD_WAIT;
          end
        S_EXT: if (rx_tvalid) r_state <= S_ABORT;
          else if (tx_tready) begin
            r_timer <= '0;
            r_state <= r_is_wr ? S_WDATA : S_RD_WAIT;
          end
        S_WDATA: if (rx_tvalid) r_state <= S_ABORT;
          else if (tx_tready) begin
            r_resp  <= RESP_OKAY;
            r_state <= S_RESP;
          end
        S_RD_WAIT: if (rx_tvalid) begin
            if (rx_tuser == RXU_REGDATA) begin
              r_rdata <= rx_tdata;
              r_resp  <= RESP_OKAY;
              r_state <= S_RESP;
            end else r_state <= S_ABORT;
          end else if (r_timer == 16'(RD_TIMEOUT - 1)) begin
            r_rdata     <= '0;
            r_resp      <= RESP_SLVERR;
            r_err_count <= sat_inc(r_err_count, RESP_SLVERR);
            r_state     <= S_RESP;
          end else r_timer <= r_timer + 16'd1;
        // The PHY must release the bus for a cycle before the command is retried.
        S_ABORT: if (!rx_tvalid) begin
          if (r_retry == 4'(MAX_RETRY - 1)) begin
            r_resp      <= RESP_SLVERR;
            r_err_count <= sat_inc(r_err_count, RESP_SLVERR);
            r_state     <= S_RESP;
          end else begin
            r_retry <= r_retry + 4'd1;
            r_state <= S_CMD;
          end
        end
        S_RESP: if (r_is_wr ? s_bready : s_rready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ulpi_reg_engine.sv
// tb_ulpi_reg_engine: directed bench; dut0 has EXT_EN=1/MAX_RETRY=4, dut1 has EXT_EN=0/MAX_RETRY=2.
module tb_ulpi_reg_engine;
  logic clk, rst;
  logic [11:0] awaddr[2], araddr[2];
  logic [31:0] wdata[2], rdata[2];
  logic [3:0]  wstrb[2];
  logic        awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
  logic        arvalid[2], arready[2], rvalid[2], rready[2];
  logic [1:0]  bresp[2], rresp[2], rx_tuser[2];
  logic [7:0]  tx_tdata[2], rx_tdata[2], err_count[2];
  logic        tx_tvalid[2], tx_tready[2], tx_tlast[2], rx_tvalid[2], busy[2];
  int total = 0, bad = 0;
  logic [9:0] txlog[$];
  logic [9:0] ex[$];
  logic [1:0] resp;
  logic [31:0] rd;
  int lat;

  ulpi_reg_engine #(.EXT_EN(1), .MAX_RETRY(4), .RD_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst),
    .s_awaddr(awaddr[0]), .s_awvalid(awvalid[0]), .s_awready(awready[0]),
    .s_wdata(wdata[0]), .s_wstrb(wstrb[0]), .s_wvalid(wvalid[0]), .s_wready(wready[0]),
    .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready[0]),
    .s_araddr(araddr[0]), .s_arvalid(arvalid[0]), .s_arready(arready[0]),
    .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(rready[0]),
    .tx_tdata(tx_tdata[0]), .tx_tvalid(tx_tvalid[0]), .tx_tready(tx_tready[0]), .tx_tlast(tx_tlast[0]),
    .rx_tdata(rx_tdata[0]), .rx_tvalid(rx_tvalid[0]), .rx_tuser(rx_tuser[0]),
    .busy(busy[0]), .err_count(err_count[0]));

  ulpi_reg_engine #(.EXT_EN(0), .MAX_RETRY(2), .RD_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst),
    .s_awaddr(awaddr[1]), .s_awvalid(awvalid[1]), .s_awready(awready[1]),
    .s_wdata(wdata[1]), .s_wstrb(wstrb[1]), .s_wvalid(wvalid[1]), .s_wready(wready[1]),
    .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready[1]),
    .s_araddr(araddr[1]), .s_arvalid(arvalid[1]), .s_arready(arready[1]),
    .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(rready[1]),
    .tx_tdata(tx_tdata[1]), .tx_tvalid(tx_tvalid[1]), .tx_tready(tx_tready[1]), .tx_tlast(tx_tlast[1]),
    .rx_tdata(rx_tdata[1]), .rx_tvalid(rx_tvalid[1]), .rx_tuser(rx_tuser[1]),
    .busy(busy[1]), .err_count(err_count[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log of accepted TX bytes: {instance, tlast, data}
  always @(posedge clk) begin
    if (!rst && tx_tvalid[0] && tx_tready[0] && !rx_tvalid[0]) txlog.push_back({1'b0, tx_tlast[0], tx_tdata[0]});
    if (!rst && tx_tvalid[1] && tx_tready[1] && !rx_tvalid[1]) txlog.push_back({1'b1, tx_tlast[1], tx_tdata[1]});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag);
    chk({tag, "_txn"}, txlog.size(), ex.size());
    for (int i = 0; i < ex.size() && i < txlog.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), 32'(txlog[i]), 32'(ex[i]));
  endtask

  task automatic idle_inputs(input int k);
    awvalid[k] = 0; wvalid[k] = 0; arvalid[k] = 0; bready[k] = 0; rready[k] = 0;
    rx_tvalid[k] = 0; rx_tuser[k] = 0; rx_tdata[k] = 0;
  endtask

  // One AXI transaction on instance k; lat counts cycles from the last command byte leaving to rvalid.
  task automatic xact(input int k, input bit wr, input logic [11:0] a, input logic [7:0] d,
                      input bit strb, input int phy_dly, input logic [7:0] phy_data,
                      input int n_abort, output logic [1:0] o_resp, output logic [31:0] o_rd,
                      output int o_lat);
    int cyc, lv, ab;
    bit got, aw_d, w_d, ar_d, rx_d;
    cyc = 0; lv = -1000; ab = n_abort; got = 0;
    aw_d = 0; w_d = 0; ar_d = 0; rx_d = 0;
    o_resp = 'x; o_rd = 'x; o_lat = -1;
    txlog.delete();
    @(negedge clk);
    if (wr) begin
      awaddr[k] = a; awvalid[k] = 1; wdata[k] = {24'h0, d}; wstrb[k] = {3'b0, strb};
      wvalid[k] = 1; bready[k] = 1;
    end else begin
      araddr[k] = a; arvalid[k] = 1; rready[k] = 1;
    end
    while (cyc < 300 && !got) begin
      @(negedge clk);
      if (aw_d) awvalid[k] = 0;
      if (w_d) wvalid[k] = 0;
      if (ar_d) arvalid[k] = 0;
      if (rx_d) rx_tvalid[k] = 0;
      aw_d = awvalid[k] && awready[k];
      w_d  = wvalid[k] && wready[k];
      ar_d = arvalid[k] && arready[k];
      rx_d = 0;
      if (wr ? bvalid[k] : rvalid[k]) begin
        got = 1; o_resp = wr ? bresp[k] : rresp[k]; o_rd = rdata[k]; o_lat = cyc - lv - 1;
      end else if (!wr && lv < 0 && tx_tvalid[k] && tx_tlast[k]) lv = cyc;
      else if (!wr && phy_dly >= 0 && lv >= 0 && cyc == lv + phy_dly) begin
        rx_tvalid[k] = 1; rx_tuser[k] = 2'b01; rx_tdata[k] = phy_data; rx_d = 1;
      end else if (wr && ab > 0 && tx_tvalid[k] && tx_tlast[k]) begin
        rx_tvalid[k] = 1; rx_tuser[k] = 2'b00; rx_tdata[k] = 8'hEE; rx_d = 1; ab--;
      end
      cyc++;
    end
    if (!got) chk("xact_timeout", 32'(cyc), 32'hFFFF_FFFF);
    @(negedge clk);
    idle_inputs(k);
  endtask

  initial begin
    bit ok;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      idle_inputs(k); awaddr[k] = 0; araddr[k] = 0; wdata[k] = 0; wstrb[k] = 0; tx_tready[k] = 1;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_bvalid", 32'(bvalid[0]), 0);
    chk("rst_rvalid", 32'(rvalid[0]), 0);
    chk("rst_txvalid", 32'(tx_tvalid[0]), 0);
    chk("rst_txlast", 32'(tx_tlast[0]), 0);
    chk("rst_err", 32'(err_count[0]), 0);
    chk("rst_awready", 32'(awready[0]), 1);
    rst = 0;
    @(negedge clk);

    // Immediate write
    xact(0, 1, 12'h00A, 8'h55, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = '{10'h08A, 10'h155}; chk_tx("wr0A");
    chk("wr0A_bresp", 32'(resp), 0);
    chk("wr0A_err", 32'(err_count[0]), 0);

    // Immediate read, PHY answers 2 cycles after the command byte
    xact(0, 0, 12'h007, 8'h00, 1, 2, 8'h3C, 0, resp, rd, lat);
    ex = '{10'h1C7}; chk_tx("rd07");
    chk("rd07_rdata", rd, 32'h0000_003C);
    chk("rd07_rresp", 32'(resp), 0);
    chk("rd07_lat", 32'(lat), 2);

    // Extended write on both configurations
    xact(0, 1, 12'h085, 8'h12, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = '{10'h0AF, 10'h085, 10'h112}; chk_tx("ext_en1");
    chk("ext_en1_bresp", 32'(resp), 0);
    xact(1, 1, 12'h085, 8'h12, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = {}; chk_tx("ext_en0");
    chk("ext_en0_bresp", 32'(resp), 2);
    chk("ext_en0_err", 32'(err_count[1]), 1);

    // Two aborts during the data byte
    xact(0, 1, 12'h004, 8'hAA, 1, -1, 8'h00, 2, resp, rd, lat);
    ex = '{10'h084, 10'h084, 10'h084, 10'h1AA}; chk_tx("retry4");
    chk("retry4_bresp", 32'(resp), 0);
    chk("retry4_err", 32'(err_count[0]), 0);
    xact(1, 1, 12'h004, 8'hAA, 1, -1, 8'h00, 2, resp, rd, lat);
    ex = '{10'h284, 10'h284}; chk_tx("retry2");
    chk("retry2_bresp", 32'(resp), 2);
    chk("retry2_err", 32'(err_count[1]), 2);

    // Read timeout
    xact(0, 0, 12'h007, 8'h00, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = '{10'h1C7}; chk_tx("tmo");
    chk("tmo_lat", 32'(lat), 16);
    chk("tmo_rdata", rd, 0);
    chk("tmo_rresp", 32'(resp), 2);
    chk("tmo_err", 32'(err_count[0]), 1);

    // Decode boundaries
    xact(0, 0, 12'h100, 8'h00, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = {}; chk_tx("dec100");
    chk("dec100_rresp", 32'(resp), 3);
    chk("dec100_err", 32'(err_count[0]), 2);
    xact(0, 1, 12'h02F, 8'h01, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = {}; chk_tx("esc2F");
    chk("esc2F_bresp", 32'(resp), 2);
    chk("esc2F_err", 32'(err_count[0]), 3);
    xact(0, 1, 12'h00A, 8'h01, 0, -1, 8'h00, 0, resp, rd, lat);
    ex = {}; chk_tx("nostrb");
    chk("nostrb_bresp", 32'(resp), 0);
    chk("nostrb_err", 32'(err_count[0]), 3);

    // Simultaneous write and read requests, then reset during the read wait
    @(negedge clk);
    awaddr[0] = 12'h001; awvalid[0] = 1; wdata[0] = 32'h77; wstrb[0] = 4'h1; wvalid[0] = 1;
    araddr[0] = 12'h002; arvalid[0] = 1; bready[0] = 1; rready[0] = 1;
    #1;
    chk("tie_awready", 32'(awready[0]), 1);
    chk("tie_arready", 32'(arready[0]), 0);
    @(posedge clk); #1;
    chk("tie_wfirst", 32'(wready[0]), 1);
    awvalid[0] = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bvalid[0]) begin ok = 1; chk("tie_bresp", 32'(bresp[0]), 0); wvalid[0] = 0; end
    end
    if (!ok) chk("tie_bvalid_seen", 0, 1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (arready[0]) ok = 1;
    end
    if (!ok) chk("tie_ar_seen", 0, 1);
    @(posedge clk); #1 arvalid[0] = 0;
    repeat (4) @(negedge clk);
    chk("rdwait_busy", 32'(busy[0]), 1);
    chk("rdwait_txvalid", 32'(tx_tvalid[0]), 0);
    rst = 1;
    @(posedge clk); #1;
    chk("mrst_busy", 32'(busy[0]), 0);
    chk("mrst_rvalid", 32'(rvalid[0]), 0);
    chk("mrst_bvalid", 32'(bvalid[0]), 0);
    chk("mrst_txvalid", 32'(tx_tvalid[0]), 0);
    chk("mrst_err", 32'(err_count[0]), 0);
    @(negedge clk);
    rst = 0;
    idle_inputs(0);

    // Engine still works after the mid-transaction reset
    xact(0, 1, 12'h03F, 8'h81, 1, -1, 8'h00, 0, resp, rd, lat);
    ex = '{10'h0BF, 10'h181}; chk_tx("post_rst");
    chk("post_rst_bresp", 32'(resp), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
